// File: rtl/packet_types.sv
// Shared node-state types: node ids, routing-table entries and join FSM states.
package packet_types;

  localparam int NODE_ID_W = 8;
  localparam int RT_SIZE   = 16;

  typedef logic [NODE_ID_W-1:0] node_id_t;

  localparam node_id_t ROOT_NODE_ID = '0;

  typedef struct packed {
    logic     valid;
    node_id_t key;
    node_id_t value;
  } routing_entry_t;

  typedef routing_entry_t [RT_SIZE-1:0] routing_table_t;

  typedef enum logic [1:0] {
    JS_INIT,
    JS_UNJOINED,
    JS_WAIT_REPLY,
    JS_JOINED
  } join_state_e;

endpackage

// File: rtl/node_state_manager_if.sv
// Update strobes from system_flit_comb plus the join-request handshake to the flit sender.
interface node_state_manager_if;
  import packet_types::*;

  logic     apply_valid;
  logic     update_parent_valid;
  node_id_t update_parent_node_id;
  logic     update_this_node_valid;
  node_id_t update_this_node_id;
  logic     update_routing_table_valid;
  node_id_t update_routing_table_key;
  node_id_t update_routing_table_value;
  logic     update_routing_id_counter_valid;
  logic     join_req_ready;
  logic     join_req_valid;

  modport master (
    output apply_valid,
    output update_parent_valid,
    output update_parent_node_id,
    output update_this_node_valid,
    output update_this_node_id,
    output update_routing_table_valid,
    output update_routing_table_key,
    output update_routing_table_value,
    output update_routing_id_counter_valid,
    output join_req_ready,
    input  join_req_valid
  );

  modport slave (
    input  apply_valid,
    input  update_parent_valid,
    input  update_parent_node_id,
    input  update_this_node_valid,
    input  update_this_node_id,
    input  update_routing_table_valid,
    input  update_routing_table_key,
    input  update_routing_table_value,
    input  update_routing_id_counter_valid,
    input  join_req_ready,
    output join_req_valid
  );

endinterface

// File: rtl/node_state_manager_routing_table_regs.sv
// Routing-table storage: overwrite on key match, else fill lowest free slot, else flag a drop.
module routing_table_regs
  import packet_types::*;
#(
  parameter int ROUTING_TABLE_SIZE = RT_SIZE
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wr_en,
  input  node_id_t       wr_key,
  input  node_id_t       wr_value,
  output routing_table_t rt_q,
  output logic           full_err
);

  localparam int IDX_W = $clog2(ROUTING_TABLE_SIZE);

  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic             free;
  logic [IDX_W-1:0] free_idx;

  // Scanning downwards lets the lowest matching / free index win.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int i = ROUTING_TABLE_SIZE - 1; i >= 0; i--) begin
      if (rt_q[i].valid && (rt_q[i].key == wr_key)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!rt_q[i].valid) begin
        free     = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rt_q     <= '0;
      full_err <= 1'b0;
    end else begin
      full_err <= 1'b0;
      if (wr_en) begin
        if (hit) begin
          rt_q[hit_idx].value <= wr_value;
        end else if (free) begin
          rt_q[free_idx] <= '{valid: 1'b1, key: wr_key, value: wr_value};
        end else begin
          full_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/node_state_manager.sv
// Registered node state fed back to system_flit_comb, plus the join FSM with timed retries.
module node_state_manager
  import packet_types::*;
#(
  parameter int       ROUTING_TABLE_SIZE = RT_SIZE,
  parameter int       JOIN_RETRY_CYCLES  = 1024,
  parameter int       MAX_JOIN_RETRIES   = 4,
  parameter node_id_t ROOT_NODE_ID       = packet_types::ROOT_NODE_ID
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 is_root,
  input  node_id_t             random_id,
  node_state_manager_if.slave  bus,
  output logic                 joined,
  output node_id_t             temporal_id,
  output node_id_t             this_node_id,
  output node_id_t             parent_node_id,
  output routing_table_t       routing_table,
  output node_id_t             routing_id_counter,
  output logic                 table_full_err,
  output logic                 counter_exhausted
);

  localparam int TIMER_W = (JOIN_RETRY_CYCLES > 1) ? $clog2(JOIN_RETRY_CYCLES) : 1;
  localparam int RETRY_W = $clog2(MAX_JOIN_RETRIES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(JOIN_RETRY_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_JOIN_RETRIES - 1);
  localparam node_id_t ID_MAX = '1;

  join_state_e        state;
  logic [TIMER_W-1:0] retry_timer;
  logic [RETRY_W-1:0] retry_cnt;

  logic apply_parent;
  logic apply_this;
  logic apply_counter;

  assign apply_parent      = bus.apply_valid & bus.update_parent_valid;
  assign apply_this        = bus.apply_valid & bus.update_this_node_valid;
  assign apply_counter     = bus.apply_valid & bus.update_routing_id_counter_valid;
  assign counter_exhausted = (routing_id_counter == ID_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= JS_INIT;
      retry_timer        <= '0;
      retry_cnt          <= '0;
      bus.join_req_valid <= 1'b0;
      joined             <= 1'b0;
      temporal_id        <= '0;
      this_node_id       <= '0;
      parent_node_id     <= '0;
      routing_id_counter <= '0;
    end else begin
      if ((state != JS_INIT) && apply_parent) begin
        parent_node_id <= bus.update_parent_node_id;
      end
      // Only a joined root hands out ids; the counter sticks at all-ones.
      if (apply_counter && is_root && joined && (routing_id_counter != ID_MAX)) begin
        routing_id_counter <= routing_id_counter + node_id_t'(1);
      end

      case (state)
        JS_INIT: begin
          if (is_root) begin
            state              <= JS_JOINED;
            joined             <= 1'b1;
            this_node_id       <= ROOT_NODE_ID;
            parent_node_id     <= ROOT_NODE_ID;
            routing_id_counter <= ROOT_NODE_ID + node_id_t'(1);
          end else begin
            state              <= JS_UNJOINED;
            temporal_id        <= random_id;
            bus.join_req_valid <= 1'b1;
          end
        end
        JS_UNJOINED: begin
          if (bus.join_req_valid && bus.join_req_ready) begin
            state              <= JS_WAIT_REPLY;
            bus.join_req_valid <= 1'b0;
            retry_timer        <= TIMER_LOAD;
          end
        end
        JS_WAIT_REPLY: begin
          // A reply beats a timeout landing in the same cycle.
          if (apply_this) begin
            state        <= JS_JOINED;
            joined       <= 1'b1;
            this_node_id <= bus.update_this_node_id;
            retry_cnt    <= '0;
          end else if (retry_timer == '0) begin
            state              <= JS_UNJOINED;
            bus.join_req_valid <= 1'b1;
            if (retry_cnt == RETRY_LAST) begin
              temporal_id <= random_id;
              retry_cnt   <= '0;
            end else begin
              retry_cnt <= retry_cnt + RETRY_W'(1);
            end
          end else begin
            retry_timer <= retry_timer - TIMER_W'(1);
          end
        end
        JS_JOINED: begin
        end
        default: state <= JS_INIT;
      endcase
    end
  end

  routing_table_regs #(
    .ROUTING_TABLE_SIZE(ROUTING_TABLE_SIZE)
  ) u_routing_table_regs (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (bus.apply_valid & bus.update_routing_table_valid),
    .wr_key   (bus.update_routing_table_key),
    .wr_value (bus.update_routing_table_value),
    .rt_q     (routing_table),
    .full_err (table_full_err)
  );

endmodule

// File: doc/node_state_manager.md
Name: node_state_manager

Overview:
Sequential node-state holder that sits directly downstream of system_flit_comb. It registers the update_* strobes that system_flit_comb produces:
- parent id
- this-node id
- routing-table entries
- routing-id counter

It feeds the registered state back to system_flit_comb's routing_table, temporal_id and routing_id_counter inputs. It also runs the join FSM, which issues join-request flits with a timed retry.

Parameters:
- ROUTING_TABLE_SIZE, 16: number of routing-table entries; must match packet_types::routing_table_t.
- JOIN_RETRY_CYCLES, 1024: cycles to wait for a join reply before re-requesting.
- MAX_JOIN_RETRIES, 4: re-requests under one temporal id before a new random_id is drawn.
- ROOT_NODE_ID, 0: node id taken by the root.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- is_root  in  1  static strap; the node is the tree root
- random_id  in  node_id_t  free-running random id source
- apply_valid  in  1  system flit consumed this cycle; qualifies every update_* input
- update_parent_valid  in  1  from system_flit_comb
- update_parent_node_id  in  node_id_t  from system_flit_comb
- update_this_node_valid  in  1  from system_flit_comb
- update_this_node_id  in  node_id_t  from system_flit_comb
- update_routing_table_valid  in  1  from system_flit_comb
- update_routing_table_key  in  node_id_t  from system_flit_comb
- update_routing_table_value  in  node_id_t  from system_flit_comb
- update_routing_id_counter_valid  in  1  from system_flit_comb
- join_req_ready  in  1  flit sender accepts the join request
- join_req_valid  out  1  join-request flit pending
- joined  out  1  node holds a final id
- temporal_id  out  node_id_t  current temporary id
- this_node_id  out  node_id_t  final node id
- parent_node_id  out  node_id_t  parent in the tree
- routing_table  out  routing_table_t  registered table
- routing_id_counter  out  node_id_t  next id to hand out (root only)
- table_full_err  out  1  one-cycle pulse: a write was dropped
- counter_exhausted  out  1  counter is at max node_id_t

Behaviour:
- **Reset values** (rst_n low, asynchronous): every output and register is 0; FSM in INIT.
- **Latency:** any applied update is visible on the outputs the cycle after apply_valid.

FSM states: INIT, UNJOINED, WAIT_REPLY, JOINED.
- **INIT:** lasts one cycle.
  - is_root=1: go to JOINED with this_node_id=ROOT_NODE_ID, parent_node_id=ROOT_NODE_ID, routing_id_counter=ROOT_NODE_ID+1.
  - is_root=0: latch temporal_id<=random_id and go to UNJOINED.
- **UNJOINED:** join_req_valid=1.
  - On valid&ready: go to WAIT_REPLY and load the retry timer with JOIN_RETRY_CYCLES-1.
  - join_req_valid stays high until ready; it is never dropped without a handshake.
- **WAIT_REPLY:** the timer decrements every cycle.
  - On apply_valid&update_this_node_valid: latch this_node_id, go to JOINED, clear retry_cnt. A parent update in the same cycle is latched too.
  - On timer==0 with no reply: retry_cnt++ and go to UNJOINED.
  - If retry_cnt reaches MAX_JOIN_RETRIES: temporal_id<=random_id and retry_cnt<=0.
  - A reply arriving in the same cycle as the timeout wins.
- **JOINED:** joined=1.
  - update_this_node_valid is ignored (the id is fixed until reset).
  - Parent updates are still accepted.
- **Parent updates:** accepted in any state except INIT.

Routing-table writes (apply_valid&update_routing_table_valid, any state):
- Key matches a valid entry: overwrite that entry's value.
- Otherwise: allocate the lowest-index invalid entry.
- No free entry: drop the write and pulse table_full_err for one cycle.
- Only one write per cycle.

Routing-id counter (apply_valid&update_routing_id_counter_valid):
- Increments only when is_root&joined.
- Saturates at all-ones; counter_exhausted=1 while at max.
- Non-root increments are ignored.

Simultaneous updates: all update types in one apply cycle are applied together; they are independent.

update_* inputs without apply_valid are ignored.

Decomposition:
- Shared package packet_types holds:
  - routing_entry_t {valid, key, value}
  - routing_table_t (array of ROUTING_TABLE_SIZE entries)
  - join_state_e enum
  - ROOT_NODE_ID
- Sub-module routing_table_regs: entry storage, match/allocate and full detection.
- FSM and counters stay in the top module.

Test Plan:
1. Reset with is_root=1 -> after one cycle: joined=1, this_node_id=0, routing_id_counter=1, join_req_valid=0.
2. is_root=0, random_id=0x5A, join_req_ready=1 -> temporal_id=0x5A and join_req_valid pulses. Then apply_valid with update_this_node_id=0x07 and update_parent_node_id=0x02 -> next cycle: joined=1, this_node_id=0x07, parent_node_id=0x02.
3. Non-root with no reply, JOIN_RETRY_CYCLES=8 -> join_req_valid re-asserts every 9 cycles. After 4 retries, temporal_id reloads from random_id=0x33.
4. Write keys 1..16 -> all valid. Write key 3 with value 0x09 -> entry 3 value becomes 0x09 with no error. Write key 0x20 -> table_full_err pulses once and the table is unchanged.
5. Root with counter at 0xFE, two increments -> 0xFF then it stays 0xFF and counter_exhausted=1.
6. Assert rst_n low mid-WAIT_REPLY -> all outputs 0 immediately. After release: INIT, then UNJOINED.
